lcd_spi_tx: RTL and testbench
=============================

// Module: lcd_spi_tx
// PURPOSE
//   Byte-level SPI master for the ILI9341 LCD, one stage downstream of the LCD init/fill sequencer.
//   Accepts one byte plus a command/data flag per load handshake and drives SCK/SDO/CSX/DCX, SPI mode 0, MSB first.
//   Holds CSX low across back-to-back bytes so pixel streams are not chopped per byte.
//   Captures the byte returned on SDI.
// PARAMETERS
//   CLK_DIV  4   SCK half-period in clock cycles (>=1); SCK = CLK/(2*CLK_DIV)
//   CS_HOLD  16  idle cycles CSX stays low after a byte before releasing (0 = release immediately)
// PORTS
//   CLK_100MHz  in   1  system clock; single clock domain
//   reset       in   1  synchronous, active-high reset
//   load        in   1  start request; accepted only when busy=0
//   in          in   8  byte to send, sampled with the accepted load
//   dc          in   1  0=command, 1=data; sampled with the accepted load, driven on DCX
//   busy        out  1  1 while a byte is in flight; load ignored while 1
//   done        out  1  one-cycle pulse when a byte completes
//   out         out  8  byte received on SDI; valid from the done cycle until the next done
//   SCK         out  1  SPI clock, idle low
//   SDO         out  1  serial data to LCD
//   SDI         in   1  serial data from LCD
//   CSX         out  1  chip select, active low
//   DCX         out  1  data/command select to LCD
// BEHAVIOUR
//   Reset: SCK=0, CSX=1, SDO=0, DCX=1, busy=0, done=0, out=8'h00; FSM=IDLE; counters cleared.
//   Reset mid-byte: all outputs return to reset values at that edge; partial byte discarded; no done.
//   FSM: IDLE -> SHIFT -> HOLD -> IDLE.
//     Load accepted in IDLE or HOLD goes to SHIFT.
//     SHIFT goes to HOLD after 8 bits.
//     HOLD returns to IDLE after CS_HOLD idle cycles.
//   Accept (cycle T, busy=0 & load=1): at T+1: busy=1, CSX=0, DCX=dc, SDO=in[7], SCK=0, shift reg=in.
//   Bit timing: each bit is CLK_DIV cycles SCK low, then CLK_DIV cycles SCK high.
//     SCK rises at T+1+(2k+1)*CLK_DIV; SDI sampled into rx shift reg on that rising edge.
//     SCK falls at T+1+(2k+2)*CLK_DIV, k=0..7; on falls k=0..6, SDO advances to the next bit (MSB first).
//   Completion: at the 8th fall (T+1+16*CLK_DIV): SCK=0, done=1 (one cycle), busy=0, out=rx byte.
//     SDO holds the last bit; FSM enters HOLD.
//   Total per isolated byte: 1 + 16*CLK_DIV cycles from accept to done.
//   HOLD: CSX stays 0; counter counts CS_HOLD cycles.
//     A load in HOLD starts the next byte exactly like IDLE, with CSX continuously 0.
//     DCX may change at that start; it is stable before the first SCK rise.
//     On expiry: CSX=1, FSM=IDLE.
//     CS_HOLD=0: CSX=1 in the done cycle; HOLD is skipped.
//   load asserted while busy=1: ignored, not queued; in/dc changes while busy have no effect.
//   load asserted in the same cycle as done (busy=0): accepted; next byte starts at the following edge.
//   Widths: divider counter $clog2(CLK_DIV+1) bits; bit counter 3 bits; hold counter $clog2(CS_HOLD+1) bits.
//     Counters saturate/clear on state change, never wrap mid-state.
// TESTING  (CLK_DIV=2, CS_HOLD=4 unless noted)
//   1. Reset: hold reset 3 cycles -> SCK=0, CSX=1, DCX=1, busy=0, done=0, out=00.
//   2. load in=8'hA5 dc=0 at T -> CSX=0, DCX=0 at T+1; SDO=1,0,1,0,0,1,0,1 on 8 rises.
//      done at T+33; CSX=1 at T+37.
//   3. SDI loopback (SDI=SDO), send 8'h3C -> out=8'h3C with done.
//      SDI tied 1 -> out=8'hFF.
//   4. Send 8'h2C dc=0, then load 8'hF8 dc=1 in the done cycle -> CSX never rises between bytes.
//      DCX=1 before first rise of byte 2; two done pulses 33 cycles apart.
//   5. Pulse load with in=8'h00 while busy at mid-byte -> ignored: bits and out unchanged, single done.
//   6. Assert reset at bit 4 of 8'hFF -> next edge CSX=1, SCK=0, busy=0; no done.
//      A fresh load afterwards completes normally.

Source files
------------

// File: rtl/lcd_spi_tx.sv
// ----------------------------------------------------------------------------
// lcd_spi_tx
//   Byte-level SPI master (mode 0, MSB first) feeding an ILI9341 LCD. One byte
//   plus a command/data flag is accepted per load handshake. CSX is held low
//   across back-to-back bytes and for CS_HOLD idle cycles afterwards, so pixel
//   streams are not chopped per byte. The byte shifted in on SDI is returned.
//
// Parameters
//   CLK_DIV  SCK half-period in clock cycles (>=1); SCK = CLK/(2*CLK_DIV)
//   CS_HOLD  idle cycles CSX stays low after a byte (0 = release at done)
//
// Ports
//   CLK_100MHz  in   system clock
//   reset       in   synchronous, active-high reset
//   load        in   start request, accepted only while busy=0
//   in[7:0]     in   byte to send, sampled with the accepted load
//   dc          in   0=command, 1=data, sampled with the accepted load
//   busy        out  high while a byte is in flight
//   done        out  one-cycle pulse when a byte completes
//   out[7:0]    out  byte received on SDI, valid from done until next done
//   SCK         out  SPI clock, idle low
//   SDO         out  serial data to LCD
//   SDI         in   serial data from LCD
//   CSX         out  chip select, active low
//   DCX         out  data/command select
// ----------------------------------------------------------------------------
module lcd_spi_tx #(
    parameter int CLK_DIV = 4,
    parameter int CS_HOLD = 16
) (
    input  logic       CLK_100MHz,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] in,
    input  logic       dc,
    output logic       busy,
    output logic       done,
    output logic [7:0] out,
    output logic       SCK,
    output logic       SDO,
    input  logic       SDI,
    output logic       CSX,
    output logic       DCX
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int HW = (CS_HOLD > 0) ? $clog2(CS_HOLD + 1) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q,   div_d;
    logic [2:0]      bit_q,   bit_d;
    logic [HW-1:0]   hold_q,  hold_d;
    logic [7:0]      tx_q,    tx_d;
    logic [7:0]      rx_q,    rx_d;
    logic [7:0]      out_q,   out_d;
    logic            sck_q,   sck_d;
    logic            sdo_q,   sdo_d;
    logic            csx_q,   csx_d;
    logic            dcx_q,   dcx_d;
    logic            done_q,  done_d;

    // ------------------------------------------------------------------------
    // State register. Every output is registered so the pins are glitch-free.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK_100MHz) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            hold_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            out_q   <= '0;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b0;
            csx_q   <= 1'b1;
            dcx_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            out_q   <= out_d;
            sck_q   <= sck_d;
            sdo_q   <= sdo_d;
            csx_q   <= csx_d;
            dcx_q   <= dcx_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        out_d   = out_q;
        sck_d   = sck_q;
        sdo_d   = sdo_q;
        csx_d   = csx_q;
        dcx_d   = dcx_q;
        done_d  = 1'b0;

        if (state_q != S_SHIFT && load) begin
            // Start a byte from IDLE or HOLD; CSX stays low when chaining.
            state_d = S_SHIFT;
            div_d   = '0;
            bit_d   = '0;
            hold_d  = '0;
            tx_d    = in;
            sdo_d   = in[7];
            sck_d   = 1'b0;
            csx_d   = 1'b0;
            dcx_d   = dc;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (!sck_q) begin
                            // Rising edge: LCD data is sampled here.
                            sck_d = 1'b1;
                            rx_d  = {rx_q[6:0], SDI};
                        end else begin
                            sck_d = 1'b0;
                            if (bit_q == 3'd7) begin
                                // Eighth fall: byte complete, SDO keeps last bit.
                                done_d = 1'b1;
                                out_d  = rx_q;
                                hold_d = '0;
                                if (CS_HOLD == 0) begin
                                    state_d = S_IDLE;
                                    csx_d   = 1'b1;
                                end else begin
                                    state_d = S_HOLD;
                                end
                            end else begin
                                bit_d = bit_q + 3'd1;
                                tx_d  = tx_q << 1;
                                sdo_d = tx_q[6];
                            end
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_IDLE;
                        csx_d   = 1'b1;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    csx_d = 1'b1;
                end
            endcase
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = done_q;
    assign out  = out_q;
    assign SCK  = sck_q;
    assign SDO  = sdo_q;
    assign CSX  = csx_q;
    assign DCX  = dcx_q;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// ----------------------------------------------------------------------------
// tb_lcd_spi_tx
//   Self-checking bench for lcd_spi_tx with CLK_DIV=2, CS_HOLD=4. Inputs are
//   driven and outputs sampled on the falling clock edge. A monitor records
//   the SDO bit seen at every SCK rise and serves SDI from a reply byte (or
//   loops SDO back), so each byte's expected wire bits and received byte come
//   straight from what was sent and what was replied.
// ----------------------------------------------------------------------------
module tb_lcd_spi_tx;

    localparam int CLK_DIV  = 2;
    localparam int CS_HOLD  = 4;
    localparam int BYTE_LAT = 1 + 16 * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] in_r = 8'h00;
    logic       dc_r = 1'b0;
    logic       busy, done, SCK, SDO, CSX, DCX;
    logic [7:0] out;
    logic       sdi;

    logic [7:0] reply_r = 8'h00;
    logic       loop_r = 1'b0;

    // Monitor state
    logic [2:0] rise_idx = 3'd0;
    logic [7:0] sdo_bits = 8'h00;
    logic       sck_prev = 1'b0;
    logic       busy_prev = 1'b0;
    logic       csx_prev = 1'b1;
    int         ndone = 0;
    int         ncsx_rise = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign sdi = loop_r ? SDO : reply_r[3'd7 - rise_idx];

    lcd_spi_tx #(
        .CLK_DIV(CLK_DIV),
        .CS_HOLD(CS_HOLD)
    ) dut (
        .CLK_100MHz(clk),
        .reset     (reset),
        .load      (load),
        .in        (in_r),
        .dc        (dc_r),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .SCK       (SCK),
        .SDO       (SDO),
        .SDI       (sdi),
        .CSX       (CSX),
        .DCX       (DCX)
    );

    // Wire-level monitor: a busy rise marks a new byte; each SCK rise
    // records SDO and advances the reply bit index.
    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            rise_idx = 3'd0;
            sdo_bits = 8'h00;
        end else if (SCK && !sck_prev) begin
            sdo_bits = {sdo_bits[6:0], SDO};
            rise_idx = rise_idx + 3'd1;
        end
        if (done) ndone++;
        if (CSX && !csx_prev) ncsx_rise++;
        sck_prev  = SCK;
        busy_prev = busy;
        csx_prev  = CSX;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Send one byte starting at the current falling edge and check it end to
    // end. intrude_at > 0 pulses a bogus load that many cycles into the byte.
    task automatic run_byte(input logic [7:0] d, input logic c, input logic [7:0] rep,
                            input logic lp, input logic [7:0] exp_out, input int intrude_at);
        int n;
        in_r = d; dc_r = c; reply_r = rep; loop_r = lp;
        load = 1'b1;
        tick();
        load = 1'b0;
        check("start_csx",  CSX,  1'b0);
        check("start_dcx",  DCX,  c);
        check("start_busy", busy, 1'b1);
        check("start_sdo",  SDO,  d[7]);
        check("start_sck",  SCK,  1'b0);
        n = 1;
        while (!done && n < 100) begin
            if (n == intrude_at) begin
                in_r = 8'h00; dc_r = ~c; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
            n++;
        end
        load = 1'b0;
        check("done_latency", n, BYTE_LAT);
        check("rx_byte",  out, exp_out);
        check("tx_bits",  sdo_bits, d);
        check("end_busy", busy, 1'b0);
        check("end_sck",  SCK,  1'b0);
        check("end_dcx",  DCX,  c);
        check("end_csx",  CSX,  1'b0);
    endtask

    typedef struct {
        logic [7:0] din;
        logic       dc;
        logic [7:0] reply;
        logic       loopback;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        int done_snap;
        int csx_snap;
        logic [7:0] d, rep;
        logic c, lp;
        int gap;

        vecs[0] = '{din: 8'hA5, dc: 1'b0, reply: 8'h00, loopback: 1'b0, exp_out: 8'h00};
        vecs[1] = '{din: 8'h3C, dc: 1'b1, reply: 8'h00, loopback: 1'b1, exp_out: 8'h3C};
        vecs[2] = '{din: 8'h55, dc: 1'b0, reply: 8'hFF, loopback: 1'b0, exp_out: 8'hFF};
        vecs[3] = '{din: 8'h81, dc: 1'b1, reply: 8'h5A, loopback: 1'b0, exp_out: 8'h5A};
        vecs[4] = '{din: 8'h00, dc: 1'b1, reply: 8'hC3, loopback: 1'b0, exp_out: 8'hC3};
        vecs[5] = '{din: 8'hFE, dc: 1'b0, reply: 8'h00, loopback: 1'b1, exp_out: 8'hFE};

        // 1. Reset state
        reset = 1'b1;
        repeat (3) tick();
        check("rst_sck",  SCK,  1'b0);
        check("rst_csx",  CSX,  1'b1);
        check("rst_dcx",  DCX,  1'b1);
        check("rst_sdo",  SDO,  1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out",  out,  8'h00);
        reset = 1'b0;
        tick();

        // 2. Isolated byte, CSX release CS_HOLD cycles after done
        run_byte(8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 0);
        repeat (CS_HOLD - 1) tick();
        check("hold_csx_low", CSX, 1'b0);
        tick();
        check("hold_csx_rel", CSX, 1'b1);
        tick();

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            run_byte(vecs[i].din, vecs[i].dc, vecs[i].reply, vecs[i].loopback,
                     vecs[i].exp_out, 0);
            repeat (CS_HOLD + 2) tick();
            check("tbl_idle_csx", CSX, 1'b1);
        end

        // 4. Back-to-back: second load in the done cycle, CSX never rises
        csx_snap  = ncsx_rise;
        done_snap = ndone;
        run_byte(8'h2C, 1'b0, 8'h12, 1'b0, 8'h12, 0);
        run_byte(8'hF8, 1'b1, 8'h00, 1'b1, 8'hF8, 0);
        tick();
        check("b2b_csx_rises", ncsx_rise - csx_snap, 0);
        check("b2b_dones", ndone - done_snap, 2);
        repeat (CS_HOLD + 2) tick();

        // 5. Load pulsed mid-byte is ignored
        done_snap = ndone;
        run_byte(8'h96, 1'b1, 8'h69, 1'b0, 8'h69, 12);
        repeat (3) tick();
        check("ign_dones", ndone - done_snap, 1);
        repeat (CS_HOLD + 2) tick();

        // 6. Reset at bit 4 of 8'hFF
        in_r = 8'hFF; dc_r = 1'b0; reply_r = 8'hAA; loop_r = 1'b0;
        load = 1'b1;
        tick();
        load = 1'b0;
        n = 1;
        while (n < 18) begin tick(); n++; end
        done_snap = ndone;
        reset = 1'b1;
        tick();
        check("mid_rst_csx",  CSX,  1'b1);
        check("mid_rst_sck",  SCK,  1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_dcx",  DCX,  1'b1);
        check("mid_rst_out",  out,  8'h00);
        reset = 1'b0;
        repeat (40) tick();
        check("mid_rst_nodone", ndone - done_snap, 0);
        run_byte(8'h7E, 1'b1, 8'h81, 1'b0, 8'h81, 0);
        repeat (CS_HOLD + 2) tick();

        // Randomized bytes with random gaps; model: wire bits are the sent
        // byte MSB first, received byte is the reply (or the sent byte when
        // looped back), CSX releases once the gap reaches CS_HOLD.
        for (int i = 0; i < 14; i++) begin
            d   = 8'($urandom);
            rep = 8'($urandom);
            c   = 1'($urandom);
            lp  = 1'($urandom);
            run_byte(d, c, rep, lp, lp ? d : rep, 0);
            gap = $urandom_range(0, 7);
            if (gap > 0) begin
                repeat (gap) tick();
                check("rnd_gap_csx", CSX, (gap >= CS_HOLD) ? 1'b1 : 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
